// File: rtl/gpio_link_arbiter_if.sv
// Bundle of requester-side and link-side signals for gpio_link_arbiter.
// master = the arbiter itself, slave = requesters plus the GPIO protocol block.
interface gpio_link_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int MSG_W   = 128
);
    localparam int OW = $clog2(NUM_REQ);

    // Handshakes: a requester holds req (and its req_msg slice) until it sees
    // its ack/err bit pulse; link_data_ready is held with a stable link_message
    // until the edge that samples link_done high (or the watchdog fires).
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*MSG_W-1:0] req_msg;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_REQ-1:0]       err;
    logic                     busy;
    logic [OW-1:0]            owner;
    logic                     link_data_ready;
    logic [MSG_W-1:0]         link_message;
    logic                     link_done;
    logic [1:0]               state_dbg;

    modport master (
        input  req, req_msg, link_done,
        output ack, err, busy, owner, link_data_ready, link_message, state_dbg
    );

    modport slave (
        output req, req_msg, link_done,
        input  ack, err, busy, owner, link_data_ready, link_message, state_dbg
    );
endinterface

// File: rtl/gpio_link_arbiter.sv
// Round-robin arbiter sharing the outbound GPIO message path among NUM_REQ requesters.
// Optional link_done watchdog enabled by defining GPIO_ARB_TIMEOUT_EN.
module gpio_link_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MSG_W      = 128,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    gpio_link_arbiter_if.master   bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic               ldr_q, ldr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               busy_q, busy_d;
    logic [GW-1:0]      gap_q, gap_d;

    logic [MSG_W-1:0]   slice [NUM_REQ];
    logic               found;
    logic [OW-1:0]      winner;
    logic [OW-1:0]      cand;

    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return OW'(s);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = bus.req_msg[g*MSG_W +: MSG_W];
    end

    // First set request at or above rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_add(rr_ptr_q, i);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        msg_d    = msg_q;
        ldr_d    = ldr_q;
        ack_d    = '0;
        err_d    = '0;
        gap_d    = gap_q;
`ifdef GPIO_ARB_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    owner_d  = winner;
                    msg_d    = slice[winner];
                    ldr_d    = 1'b1;
                    state_d  = ST_SEND;
                    rr_ptr_d = wrap_add(winner, 1);
`ifdef GPIO_ARB_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                end
            end
            ST_SEND: begin
                // link_done wins over a watchdog expiry on the same edge.
                if (bus.link_done) begin
                    ldr_d          = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    state_d        = ST_GAP;
                    gap_d          = '0;
                end
`ifdef GPIO_ARB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    ldr_d          = 1'b0;
                    err_d[owner_q] = 1'b1;
                    state_d        = ST_GAP;
                    gap_d          = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else                               gap_d   = gap_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            msg_q    <= '0;
            ldr_q    <= 1'b0;
            ack_q    <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            gap_q    <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            msg_q    <= msg_d;
            ldr_q    <= ldr_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            gap_q    <= gap_d;
`ifdef GPIO_ARB_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign bus.ack             = ack_q;
    assign bus.err             = err_q;
    assign bus.busy            = busy_q;
    assign bus.owner           = owner_q;
    assign bus.link_data_ready = ldr_q;
    assign bus.link_message    = msg_q;
    assign bus.state_dbg       = state_q;
endmodule

// File: tb/tb_gpio_link_arbiter.sv
// Bench for gpio_link_arbiter: transfer-level reference model with per-cycle compare,
// plus directed scenarios with hand-computed expectations.
module tb_gpio_link_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int MSG_W      = 128;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 64;
    localparam int OW         = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    gpio_link_arbiter_if #(.NUM_REQ(NUM_REQ), .MSG_W(MSG_W)) bus ();

    gpio_link_arbiter #(
        .NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transfer is either in flight (m_xfer), cooling down (m_gap cycles left) or idle.
    bit                 m_xfer;
    int                 m_gap;
    int                 m_ptr;
    int                 m_owner;
    int                 m_tmo;
    logic [MSG_W-1:0]   m_msg;
    logic [NUM_REQ-1:0] m_ack;
    logic [NUM_REQ-1:0] m_err;
    logic [MSG_W-1:0]   exp_q[$];
    int                 grant_log[$];
    logic               ldr_prev;

    always @(posedge clock) begin
        m_ack = '0;
        m_err = '0;
        if (reset) begin
            m_xfer = 0; m_gap = 0; m_ptr = 0; m_owner = 0; m_tmo = 0; m_msg = '0;
        end else if (m_xfer) begin
            if (bus.link_done) begin
                m_ack  = NUM_REQ'(1) << m_owner;
                m_xfer = 0;
                m_gap  = GAP_CYCLES;
            end
`ifdef GPIO_ARB_TIMEOUT_EN
            else begin
                m_tmo++;
                if (m_tmo == TIMEOUT) begin
                    m_err  = NUM_REQ'(1) << m_owner;
                    m_xfer = 0;
                    m_gap  = GAP_CYCLES;
                end
            end
`endif
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                int idx;
                idx = (m_ptr + i) % NUM_REQ;
                if (!m_xfer && bus.req[idx[OW-1:0]]) begin
                    m_owner = idx;
                    m_msg   = MSG_W'(bus.req_msg >> (idx * MSG_W));
                    m_xfer  = 1;
                    m_ptr   = (idx + 1) % NUM_REQ;
                    m_tmo   = 0;
                    exp_q.push_back(m_msg);
                end
            end
        end
    end

    // ---------------- scoreboard / per-cycle compare ----------------
    initial ldr_prev = 1'b0;
    always @(negedge clock) begin
        check("link_data_ready", MSG_W'(bus.link_data_ready), MSG_W'(m_xfer));
        check("busy", MSG_W'(bus.busy), MSG_W'(m_xfer || (m_gap > 0)));
        check("owner", MSG_W'(bus.owner), MSG_W'(m_owner));
        check("link_message", bus.link_message, m_msg);
        check("ack", MSG_W'(bus.ack), MSG_W'(m_ack));
        check("err", MSG_W'(bus.err), MSG_W'(m_err));
        check("ack_err_onehot", MSG_W'($countones(bus.ack | bus.err) <= 1), MSG_W'(1));
        if (bus.link_data_ready && !ldr_prev) begin
            grant_log.push_back(int'(bus.owner));
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL grant_msg: got grant with message %0h expected no grant at %0t", bus.link_message, $time);
            end else begin
                check("grant_msg", bus.link_message, exp_q.pop_front());
            end
        end
        ldr_prev = bus.link_data_ready;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic wait_ldr(input string name);
        int n;
        n = 0;
        while (!bus.link_data_ready && n < 50) begin
            step();
            n++;
        end
        check(name, MSG_W'(bus.link_data_ready), MSG_W'(1));
    endtask

    task automatic serve(input int delay);
        wait_ldr("serve_grant");
        repeat (delay - 1) step();
        bus.link_done = 1'b1;
        step();
        bus.link_done = 1'b0;
    endtask

    function automatic logic [MSG_W-1:0] pat(input int i);
        return {4{32'hC0DE_0000 + 32'(i)}};
    endfunction

    int rr_exp [5] = '{0, 1, 2, 3, 0};
    int t6_req [4] = '{4'b1010, 4'b0110, 4'b1001, 4'b0100};
    int t6_own [4] = '{1, 2, 3, 2};
    int t6_dly [4] = '{1, 3, 2, 4};

    // ---------------- directed stimulus ----------------
    initial begin
        bus.req       = '0;
        bus.req_msg   = '0;
        bus.link_done = 1'b0;
        reset         = 1'b1;
        repeat (3) step();
        check("rst_busy", MSG_W'(bus.busy), '0);
        check("rst_ldr", MSG_W'(bus.link_data_ready), '0);
        check("rst_owner", MSG_W'(bus.owner), '0);
        check("rst_msg", bus.link_message, '0);
        check("rst_ack", MSG_W'(bus.ack), '0);
        reset = 1'b0;
        step();

        // single request, done 6 cycles after data_ready rises
        bus.req_msg[1*MSG_W +: MSG_W] = {4{32'hA5A5_A5A5}};
        bus.req = 4'b0010;
        wait_ldr("t1_grant");
        check("t1_owner", MSG_W'(bus.owner), MSG_W'(1));
        check("t1_msg", bus.link_message, {4{32'hA5A5_A5A5}});
        repeat (5) step();
        bus.link_done = 1'b1;
        step();
        bus.link_done = 1'b0;
        check("t1_ack", MSG_W'(bus.ack), MSG_W'(4'b0010));
        check("t1_ldr_low", MSG_W'(bus.link_data_ready), '0);
        step();
        bus.req = '0;
        check("t1_ack_pulse", MSG_W'(bus.ack), '0);
        check("t1_gap_busy", MSG_W'(bus.busy), MSG_W'(1));
        step();
        check("t1_idle", MSG_W'(bus.busy), '0);
        repeat (2) step();

        // round robin with all requesting
        do_reset();
        grant_log.delete();
        bus.req = 4'b1111;
        repeat (5) serve(1);
        bus.req = '0;
        repeat (4) step();
        check("t2_grants", MSG_W'(grant_log.size()), MSG_W'(5));
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size()) check("t2_order", MSG_W'(grant_log[i]), MSG_W'(rr_exp[i]));

        // message latched at grant
        bus.req_msg[0 +: MSG_W] = 128'h1;
        bus.req = 4'b0001;
        wait_ldr("t3_grant");
        repeat (2) step();
        bus.req_msg[0 +: MSG_W] = 128'h2;
        repeat (2) step();
        check("t3_msg_held", bus.link_message, 128'h1);
        bus.link_done = 1'b1;
        step();
        bus.link_done = 1'b0;
        check("t3_ack", MSG_W'(bus.ack), MSG_W'(4'b0001));
        bus.req = '0;
        repeat (3) step();

        // reset in the middle of SEND
        bus.req_msg[0 +: MSG_W] = 128'h3C;
        bus.req = 4'b0001;
        wait_ldr("t4_grant");
        repeat (3) step();
        reset = 1'b1;
        step();
        check("t4_ldr", MSG_W'(bus.link_data_ready), '0);
        check("t4_busy", MSG_W'(bus.busy), '0);
        check("t4_owner", MSG_W'(bus.owner), '0);
        check("t4_ack", MSG_W'(bus.ack), '0);
        check("t4_err", MSG_W'(bus.err), '0);
        reset = 1'b0;
        serve(2);
        check("t4_ack_after", MSG_W'(bus.ack), MSG_W'(4'b0001));
        bus.req = '0;
        repeat (3) step();

        // stray done while idle
        bus.link_done = 1'b1;
        step();
        bus.link_done = 1'b0;
        check("t5_ack", MSG_W'(bus.ack), '0);
        check("t5_busy", MSG_W'(bus.busy), '0);
        step();
        check("t5_ack2", MSG_W'(bus.ack), '0);

        // mixed request patterns; rr_ptr starts at 1 here
        for (int i = 0; i < NUM_REQ; i++) bus.req_msg[i*MSG_W +: MSG_W] = pat(i);
        for (int t = 0; t < 4; t++) begin
            bus.req = NUM_REQ'(t6_req[t]);
            serve(t6_dly[t]);
            check("t6_owner", MSG_W'(bus.owner), MSG_W'(t6_own[t]));
            check("t6_ack", MSG_W'(bus.ack), MSG_W'(1) << t6_own[t]);
            bus.link_done = 1'b1;
            step();
            bus.link_done = 1'b0;
            bus.req = '0;
            check("t6_gap_done_ignored", MSG_W'(bus.ack), '0);
            repeat (3) step();
        end

`ifdef GPIO_ARB_TIMEOUT_EN
        begin
            int n;
            bus.req = 4'b0100;
            wait_ldr("t7_grant");
            n = 0;
            while (bus.err == '0 && n < 100) begin
                step();
                n++;
            end
            check("t7_cycles", MSG_W'(n), MSG_W'(64));
            check("t7_err", MSG_W'(bus.err), MSG_W'(4'b0100));
            check("t7_no_ack", MSG_W'(bus.ack), '0);
            step();
            bus.req = '0;
            check("t7_err_pulse", MSG_W'(bus.err), '0);
            repeat (4) step();

            bus.req = 4'b0100;
            wait_ldr("t8_grant");
            repeat (63) step();
            bus.link_done = 1'b1;
            step();
            bus.link_done = 1'b0;
            check("t8_ack", MSG_W'(bus.ack), MSG_W'(4'b0100));
            check("t8_no_err", MSG_W'(bus.err), '0);
            bus.req = '0;
            repeat (4) step();
        end
`endif

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
